instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encodes field-level RV32I instruction descriptions (I-type ALU, R-type ALU, S-type store, ebreak) into 32-bit words.
- Writes the words sequentially into instruction memory from word address 0. It is the program-load front end feeding the instruction stream that the control/decode stage later consumes.
- On a finish request it appends a terminating ebreak and locks until reset.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words (last slot reserved for ebreak).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- in_kind  input  2  0=I-type ALU, 1=R-type, 2=S-type, 3=ebreak
- in_rd  input  5  destination register (I/R)
- in_rs1  input  5  source 1 (I/R/S)
- in_rs2  input  5  source 2 (R/S)
- in_funct3  input  3  funct3 (I/R/S)
- in_funct7  input  7  funct7 (R)
- in_imm12  input  12  immediate (I/S)
- finish  input  1  append ebreak and stop
- mem_we  output  1  instruction-memory write strobe
- mem_addr  output  ADDR_W  word address of write
- mem_wdata  output  32  encoded instruction
- count  output  ADDR_W+1  words written so far, ebreak included
- done  output  1  program terminated; block locked
- overflow  output  1  sticky: bundle offered while full
- illegal  output  1  sticky: bundle rejected by field check (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, dominant over all inputs):
  - state=LOAD, write pointer=0, count=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, done=0, overflow=0, illegal=0.
  - Memory contents are not touched. Reset mid-load discards progress; the next bundle writes address 0.
- States:
  - LOAD: accepting bundles.
  - TERM: writing ebreak.
  - DONE: terminal.
- Handshake:
  - in_ready = (state==LOAD) && (ptr < DEPTH-1); combinational from state/pointer.
  - Transfer occurs on clk edge when in_valid && in_ready.
- Latency:
  - A bundle accepted at edge N produces mem_we=1 with mem_addr/mem_wdata during cycle N+1 (all outputs registered).
  - mem_we is a 1-cycle pulse per word. Back-to-back transfers give one write per cycle.
- Pointer and count increment by 1 per written word.
- Encodings:
  - I: {imm12, rs1, funct3, rd, 7'b0010011}
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - S: {imm12[11:5], rs2, rs1, funct3, imm12[4:0], 7'b0100011}
  - in_kind=3: 32'h00100073 (all fields ignored).
- Full condition:
  - When ptr==DEPTH-1, in_ready=0.
  - in_valid=1 in LOAD while full sets overflow (sticky until reset); the bundle is dropped, nothing is written.
- finish (sampled only in LOAD):
  - With no simultaneous transfer: go to TERM.
  - finish and a transfer on the same edge: the bundle is written first at ptr, then ebreak at ptr+1 on the next cycle.
- TERM: issues one ebreak write at the current pointer, then goes to DONE.
- DONE:
  - done=1, in_ready=0, mem_we=0.
  - finish and in_valid are ignored; overflow is not set in DONE.
- A finish with zero bundles writes ebreak at address 0; count=1.
- An explicit in_kind=3 bundle is an ordinary word; it does not terminate.

Optional Feature:
- Macro: ENC_FIELD_CHECK_EN.
- Defined:
  - R-type with funct7 not in {7'b0000000, 7'b0100000}, or S-type with funct3 > 3'b010, is accepted (handshake completes) but not written.
  - Pointer and count unchanged; illegal is set (sticky until reset).
- Undefined:
  - illegal is tied 0.
  - S-type funct3[2] is forced to 0; R-type funct7 is passed through unmodified.

Test Plan:
- Reset, then I-type rd=1 rs1=0 funct3=0 imm=5 -> next cycle mem_we=1, addr=0, wdata=0x00500093, count=1.
- Back-to-back R-type rd=3 rs1=1 rs2=2 funct3=0 funct7=0, then S-type rs1=1 rs2=2 funct3=2 imm=8 -> writes 0x002081B3 @0 and 0x0020A423 @1 on consecutive cycles.
- ADDR_W=2: three I-type bundles, then in_valid held -> in_ready=0 after third, overflow=1, no write; finish -> 0x00100073 @3, done=1, count=4.
- finish asserted on the same edge as a transfer -> bundle @ptr, ebreak @ptr+1 next cycle, then done; further in_valid/finish produce no writes.
- rst pulsed mid-stream after two writes -> all outputs zero next cycle; next bundle writes addr 0, count=1.
- With ENC_FIELD_CHECK_EN: R-type funct7=7'b0000001 -> no write, illegal=1, count unchanged. Without it: the same bundle encodes with funct7 intact, illegal=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that streams words into instruction memory from address 0.
// Optional field legality check enabled by defining ENC_FIELD_CHECK_EN.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [11:0]       in_imm12,
    input  logic              finish,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overflow,
    output logic              illegal
);

    localparam logic [6:0]  OP_I   = 7'b0010011;
    localparam logic [6:0]  OP_R   = 7'b0110011;
    localparam logic [6:0]  OP_S   = 7'b0100011;
    localparam logic [31:0] EBREAK = 32'h00100073;

    localparam logic [1:0] KIND_I = 2'd0;
    localparam logic [1:0] KIND_R = 2'd1;
    localparam logic [1:0] KIND_S = 2'd2;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_TERM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                illegal_q, illegal_d;

    logic [31:0]         enc_c;
    logic                bad_c;
    logic [2:0]          s_funct3_c;
    logic                full_c;
    logic                xfer_c;

    // Last slot is held back so the terminating ebreak always fits.
    assign full_c   = &ptr_q;
    assign in_ready = (state_q == ST_LOAD) && !full_c;
    assign xfer_c   = in_valid && in_ready;

    // Instruction encoder and optional field legality check.
    always_comb begin
        bad_c      = 1'b0;
        s_funct3_c = in_funct3;
`ifdef ENC_FIELD_CHECK_EN
        if (in_kind == KIND_R && in_funct7 != 7'b0000000 && in_funct7 != 7'b0100000) begin
            bad_c = 1'b1;
        end
        if (in_kind == KIND_S && in_funct3 > 3'b010) begin
            bad_c = 1'b1;
        end
`else
        s_funct3_c = {1'b0, in_funct3[1:0]};
`endif
        case (in_kind)
            KIND_I:  enc_c = {in_imm12, in_rs1, in_funct3, in_rd, OP_I};
            KIND_R:  enc_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            KIND_S:  enc_c = {in_imm12[11:5], in_rs2, in_rs1, s_funct3_c, in_imm12[4:0], OP_S};
            default: enc_c = EBREAK;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid && full_c) begin
                    overflow_d = 1'b1;
                end
                if (xfer_c) begin
                    if (bad_c) begin
                        illegal_d = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = enc_c;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        count_d     = count_q + (ADDR_W + 1)'(1);
                    end
                end
                if (finish) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = ptr_q;
                mem_wdata_d = EBREAK;
                ptr_d       = ptr_q + ADDR_W'(1);
                count_d     = count_q + (ADDR_W + 1)'(1);
                done_d      = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule
